axis_frame_gen: RTL and testbench



---
 rtl/axis_frame_gen_pkg.sv | 30 +++
 rtl/axis_frame_gen_lfsr.sv | 27 ++
 rtl/axis_frame_gen.sv | 177 +++++++++++++++++
 tb/tb_axis_frame_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_gen_pkg.sv
// Shared types and constants for the AXI-Stream frame generator: FSM states,
// LFSR polynomial/seed, and the last-beat tkeep helper.
package axis_frame_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  // Galois right-shift form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

  localparam int unsigned MAX_KEEP_WIDTH = 128;

  // Low 'rem' bits set; a zero remainder means the last beat is full.
  function automatic logic [MAX_KEEP_WIDTH-1:0] last_keep(input int unsigned rem,
                                                          input int unsigned keep_width);
    logic [MAX_KEEP_WIDTH-1:0] mask;
    int unsigned               nbytes;
    nbytes = (rem == 0) ? keep_width : rem;
    mask   = '0;
    for (int unsigned i = 0; i < MAX_KEEP_WIDTH; i++) begin
      mask[i] = (i < nbytes);
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_frame_gen_lfsr.sv
// 32-bit Galois LFSR payload source; reloads the seed on 'load' and steps
// once per 'advance'. next_value exposes the step result for look-ahead.
module axis_frame_gen_lfsr
  import axis_frame_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] value,
  output logic [31:0] next_value
);

  assign next_value = {1'b0, value[31:1]} ^ (value[0] ? LFSR_POLY : 32'h0);

  // NOTE: clocked state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else if (load) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: programmable frame length/count, inter-frame gap,
// backpressure-safe registered outputs. Define AXIS_FRAME_GEN_PRBS_EN for LFSR payload.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int IFG_CYCLES = 2
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [15:0]           frame_count,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           frames_sent
);

  localparam logic [LEN_WIDTH-1:0] BEAT_BYTES   = LEN_WIDTH'(KEEP_WIDTH);
  localparam logic [LEN_WIDTH:0]   BEAT_BYTES_W = (LEN_WIDTH + 1)'(KEEP_WIDTH);
  localparam logic [7:0]           IFG_LAST     = (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] byte_base;
  logic [15:0]          frames_left;
  logic [7:0]           ifg_cnt;

  logic                  start_ok;
  logic                  beat_accept;
  logic                  last_accept;
  logic                  more_frames;
  logic                  gap_exit;
  logic                  load_beat;
  logic [LEN_WIDTH-1:0]  len_sel;
  logic [LEN_WIDTH-1:0]  base_sel;
  logic [LEN_WIDTH:0]    bytes_left;
  logic                  nxt_last;
  int unsigned           last_rem;
  logic [MAX_KEEP_WIDTH-1:0] keep_full;
  logic [KEEP_WIDTH-1:0] nxt_keep;
  logic [DATA_WIDTH-1:0] nxt_data;

`ifdef AXIS_FRAME_GEN_PRBS_EN
  logic [31:0] lfsr_q;
  logic [31:0] lfsr_next;
  logic [31:0] prbs_word;

  axis_frame_gen_lfsr u_lfsr (
    .clk        (m_axis_aclk),
    .rst_n      (m_axis_aresetn),
    .load       (start_ok),
    .advance    (beat_accept),
    .value      (lfsr_q),
    .next_value (lfsr_next)
  );

  // The beat being registered must carry the LFSR value it will hold once live.
  always_comb begin
    prbs_word = lfsr_q;
    if (start_ok)         prbs_word = LFSR_SEED;
    else if (beat_accept) prbs_word = lfsr_next;
  end
`endif

  // NOTE: every signal gets a value before any branch, so no latches are inferred.
  always_comb begin
    start_ok    = (state == ST_IDLE) && start && (frame_len != '0) && (frame_count != '0);
    beat_accept = m_axis_tvalid && m_axis_tready;
    last_accept = (state == ST_SEND) && beat_accept && m_axis_tlast;
    more_frames = (frames_left != 16'd1) && !stop;
    gap_exit    = (state == ST_GAP) && !stop && (ifg_cnt == 8'd0);
    load_beat   = start_ok || gap_exit ||
                  ((state == ST_SEND) && beat_accept &&
                   (!m_axis_tlast || (more_frames && (IFG_CYCLES == 0))));

    // Next beat starts at the following byte offset, or at 0 for a new frame.
    len_sel    = start_ok ? frame_len : len_q;
    base_sel   = ((state == ST_SEND) && !m_axis_tlast) ? byte_base + BEAT_BYTES : '0;
    bytes_left = {1'b0, len_sel} - {1'b0, base_sel};
    nxt_last   = (bytes_left <= BEAT_BYTES_W);
    last_rem   = (nxt_last && (bytes_left != BEAT_BYTES_W)) ? 32'(bytes_left) : 32'd0;
    keep_full  = last_keep(last_rem, KEEP_WIDTH);
    nxt_keep   = keep_full[KEEP_WIDTH-1:0];

    nxt_data = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      if (nxt_keep[j]) begin
`ifdef AXIS_FRAME_GEN_PRBS_EN
        nxt_data[8*j +: 8] = prbs_word[8*(j%4) +: 8];
`else
        nxt_data[8*j +: 8] = base_sel[7:0] + 8'(j);
`endif
      end
    end
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      frames_sent   <= '0;
      len_q         <= '0;
      frames_left   <= '0;
      ifg_cnt       <= '0;
      byte_base     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state       <= ST_SEND;
            busy        <= 1'b1;
            len_q       <= frame_len;
            frames_left <= frame_count;
            frames_sent <= '0;
          end
        end
        ST_SEND: begin
          if (last_accept) begin
            frames_sent <= frames_sent + 32'd1;
            frames_left <= frames_left - 16'd1;
            if (!more_frames) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (IFG_CYCLES != 0) begin
              state   <= ST_GAP;
              ifg_cnt <= IFG_LAST;
            end
          end
        end
        ST_GAP: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (ifg_cnt == 8'd0) begin
            state <= ST_SEND;
          end else begin
            ifg_cnt <= ifg_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Output beat only changes on load or when the final beat is taken.
      if (load_beat) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= nxt_data;
        m_axis_tkeep  <= nxt_keep;
        m_axis_tlast  <= nxt_last;
        byte_base     <= base_sel;
      end else if (beat_accept) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed self-checking bench for axis_frame_gen (default incrementing payload,
// 64-bit data, IFG_CYCLES = 2).
module tb_axis_frame_gen;

  localparam int IFG = 2;

  logic        clk;
  logic        aresetn;
  logic        start;
  logic        stop;
  logic [15:0] frame_len;
  logic [15:0] frame_count;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        busy;
  logic        done;
  logic [31:0] frames_sent;

  int checks = 0;
  int errors = 0;

  axis_frame_gen #(
    .DATA_WIDTH (64),
    .KEEP_WIDTH (8),
    .LEN_WIDTH  (16),
    .IFG_CYCLES (IFG)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (aresetn),
    .start          (start),
    .stop           (stop),
    .frame_len      (frame_len),
    .frame_count    (frame_count),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tdata   (tdata),
    .m_axis_tkeep   (tkeep),
    .m_axis_tlast   (tlast),
    .busy           (busy),
    .done           (done),
    .frames_sent    (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference beat model: byte i of a frame is i[7:0], bytes past the length are 0.
  function automatic logic [63:0] exp_data(input int len, input int b);
    logic [63:0] d;
    d = '0;
    for (int j = 0; j < 8; j++) begin
      if (8*b + j < len) d[8*j +: 8] = 8'(8*b + j);
    end
    return d;
  endfunction

  function automatic logic [7:0] exp_keep(input int len, input int b);
    logic [7:0] k;
    for (int j = 0; j < 8; j++) k[j] = (8*b + j < len);
    return k;
  endfunction

  function automatic logic exp_last(input int len, input int b);
    return (8*b + 8 >= len);
  endfunction

  task automatic do_start(input int len, input int cnt);
    frame_len   = 16'(len);
    frame_count = 16'(cnt);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // Consumes one frame, checking each accepted beat and stall stability.
  // stop is raised while beat index stop_beat is on the bus (-1 disables).
  task automatic expect_frame(input string tag, input int len, input int stop_beat, input bit rnd);
    int          nbeats;
    int          b;
    int          cycles;
    bit          stalled;
    bit          ready_now;
    logic [63:0] hd;
    logic [7:0]  hk;
    logic        hl;
    nbeats  = (len + 7) / 8;
    b       = 0;
    cycles  = 0;
    stalled = 1'b0;
    hd = '0; hk = '0; hl = 1'b0;
    while (b < nbeats && cycles < 1000) begin
      check({tag, "/tvalid"}, 64'(tvalid), 64'd1);
      if (stalled) begin
        check({tag, "/hold_data"}, tdata, hd);
        check({tag, "/hold_keep_last"}, 64'({tkeep, tlast}), 64'({hk, hl}));
      end
      if (b == stop_beat) stop = 1'b1;
      ready_now = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tready    = ready_now;
      if (tvalid && ready_now) begin
        check({tag, "/tdata"}, tdata, exp_data(len, b));
        check({tag, "/tkeep"}, 64'(tkeep), 64'(exp_keep(len, b)));
        check({tag, "/tlast"}, 64'(tlast), 64'(exp_last(len, b)));
        b++;
        stalled = 1'b0;
      end else begin
        hd = tdata; hk = tkeep; hl = tlast;
        stalled = tvalid;
      end
      tick();
      cycles++;
    end
    if (b < nbeats) check({tag, "/beat_timeout"}, 64'(b), 64'(nbeats));
  endtask

  task automatic expect_gap(input string tag);
    for (int i = 0; i < IFG; i++) begin
      check({tag, "/gap_idle"}, 64'(tvalid), 64'd0);
      tick();
    end
  endtask

  task automatic expect_end(input string tag, input int sent);
    check({tag, "/done"}, 64'(done), 64'd1);
    check({tag, "/busy_low"}, 64'(busy), 64'd0);
    check({tag, "/tvalid_low"}, 64'(tvalid), 64'd0);
    check({tag, "/frames_sent"}, 64'(frames_sent), 64'(sent));
    tick();
    check({tag, "/done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit any_valid;
    aresetn     = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    frame_len   = '0;
    frame_count = '0;
    tready      = 1'b1;

    // Reset state
    tick();
    check("rst/tvalid", 64'(tvalid), 64'd0);
    check("rst/tdata", tdata, 64'd0);
    check("rst/tkeep_tlast", 64'({tkeep, tlast}), 64'd0);
    check("rst/busy_done", 64'({busy, done}), 64'd0);
    check("rst/frames_sent", 64'(frames_sent), 64'd0);
    aresetn = 1'b1;
    tick();

    // 20-byte single frame: FF, FF, 0F
    do_start(20, 1);
    check("t1/busy", 64'(busy), 64'd1);
    check("t1/first_data", tdata, 64'h0706_0504_0302_0100);
    expect_frame("t1", 20, -1, 1'b0);
    expect_end("t1", 1);

    // Three 16-byte frames with the inter-frame gap
    do_start(16, 3);
    for (int f = 0; f < 3; f++) begin
      expect_frame("t2", 16, -1, 1'b0);
      if (f < 2) begin
        check("t2/frames_mid", 64'(frames_sent), 64'(f + 1));
        check("t2/no_done_mid", 64'(done), 64'd0);
        expect_gap("t2");
      end
    end
    expect_end("t2", 3);

    // Random backpressure on a 100-byte frame
    do_start(100, 1);
    expect_frame("t3", 100, -1, 1'b1);
    tready = 1'b1;
    expect_end("t3", 1);

    // stop during beat 2 of frame 4 finishes that frame only
    do_start(24, 10);
    for (int f = 0; f < 3; f++) begin
      expect_frame("t4", 24, -1, 1'b0);
      expect_gap("t4");
    end
    expect_frame("t4/f4", 24, 1, 1'b0);
    stop = 1'b0;
    expect_end("t4", 4);
    any_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      any_valid |= tvalid;
      tick();
    end
    check("t4/no_more_valid", 64'(any_valid), 64'd0);

    // Zero length / zero count starts are ignored
    do_start(0, 1);
    check("t5/len0_busy", 64'({busy, tvalid}), 64'd0);
    tick();
    check("t5/len0_done", 64'(done), 64'd0);
    do_start(8, 0);
    check("t5/cnt0_busy", 64'({busy, tvalid}), 64'd0);
    tick();
    check("t5/cnt0_done", 64'(done), 64'd0);

    // start while busy (with new length/count) does not disturb the run
    do_start(20, 2);
    tready = 1'b0;
    tick();
    frame_len   = 16'd8;
    frame_count = 16'd5;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    check("t5/busy_kept", 64'(busy), 64'd1);
    expect_frame("t5", 20, -1, 1'b0);
    expect_gap("t5");
    expect_frame("t5", 20, -1, 1'b0);
    expect_end("t5", 2);

    // Asynchronous reset mid-frame, then a clean frame
    do_start(16, 3);
    expect_frame("t6a", 16, -1, 1'b0);
    check("t6/frames_before", 64'(frames_sent), 64'd1);
    expect_gap("t6a");
    tready = 1'b0;
    check("t6/valid_before", 64'(tvalid), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("t6/async_tvalid", 64'(tvalid), 64'd0);
    check("t6/async_busy", 64'(busy), 64'd0);
    check("t6/async_frames", 64'(frames_sent), 64'd0);
    check("t6/async_tdata", tdata, 64'd0);
    tick();
    aresetn = 1'b1;
    tready  = 1'b1;
    tick();
    do_start(20, 1);
    check("t6/busy", 64'(busy), 64'd1);
    expect_frame("t6b", 20, -1, 1'b0);
    expect_end("t6b", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
